// File: rtl/fir_mac_sequencer_if.sv
// Sample/coefficient handshake plus SRAM and MAC control bus of the FIR upstream stage.
// The master side drives samples and coefficient writes; the slave side is the sequencer.
interface fir_mac_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              en_sample;
   logic [2:0]        fir_in;
   logic              coeff_update_flag;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              csn_ram;
   logic              wrn_ram;
   logic [ADDR_W-1:0] addr_ram;
   logic [15:0]       wr_dt_ram;
   logic [29:0]       delay;
   logic              en_mul;
   logic              en_add_acc;
   logic              mac_valid;
   logic              busy;
   logic              ovr;

   modport master (
      output en_sample, fir_in, coeff_update_flag, wr_en, wr_addr, wr_data,
      input  csn_ram, wrn_ram, addr_ram, wr_dt_ram, delay,
      input  en_mul, en_add_acc, mac_valid, busy, ovr
   );

   modport slave (
      input  en_sample, fir_in, coeff_update_flag, wr_en, wr_addr, wr_data,
      output csn_ram, wrn_ram, addr_ram, wr_dt_ram, delay,
      output en_mul, en_add_acc, mac_valid, busy, ovr
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR control stage: 10-tap delay line, per-sample coefficient read sweep with MAC enables,
// and coefficient-load arbitration onto the single-port SRAM while idle.
module fir_mac_sequencer #(
   parameter int NTAP   = 10,
   parameter int ADDR_W = 4
) (
   input  logic               iClk12M,
   input  logic               iRst,
   fir_mac_sequencer_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_VALID = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] tap_cnt;
   logic              csn_q;
   logic              wrn_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [29:0]       delay_q;
   logic              en_q;
   logic              valid_q;
   logic              ovr_q;

   logic idle;
   logic accept;
   logic write_ok;

   // The update flag decides between a sample and a write that arrive together in IDLE.
   assign idle     = (state == S_IDLE);
   assign accept   = idle && bus.en_sample && !bus.coeff_update_flag;
   assign write_ok = idle && bus.coeff_update_flag && bus.wr_en &&
                     (bus.wr_addr < ADDR_W'(NTAP));

   // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block and every
   // register, including the delay line, gets an explicit value in the reset branch.
   always_ff @(posedge iClk12M) begin
      if (iRst) begin
         state   <= S_IDLE;
         tap_cnt <= '0;
         csn_q   <= 1'b1;
         wrn_q   <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         delay_q <= '0;
         en_q    <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         // Enables trail the address by one cycle to line up with SRAM read data.
         en_q    <= (state == S_READ);
         valid_q <= 1'b0;
         csn_q   <= 1'b1;
         wrn_q   <= 1'b1;
         if (bus.en_sample && !idle)
            ovr_q <= 1'b1;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  delay_q <= {delay_q[26:0], bus.fir_in};
                  csn_q   <= 1'b0;
                  addr_q  <= '0;
                  tap_cnt <= ADDR_W'(1);
                  state   <= S_READ;
               end else if (write_ok) begin
                  csn_q   <= 1'b0;
                  wrn_q   <= 1'b0;
                  addr_q  <= bus.wr_addr;
                  wdata_q <= bus.wr_data;
               end
            end
            // tap_cnt holds the next address to issue; address 0 goes out on accept.
            S_READ: begin
               if (tap_cnt == ADDR_W'(NTAP)) begin
                  state <= S_DRAIN;
               end else begin
                  csn_q   <= 1'b0;
                  addr_q  <= tap_cnt;
                  tap_cnt <= tap_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               valid_q <= 1'b1;
               state   <= S_VALID;
            end
            S_VALID: begin
               tap_cnt <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.csn_ram    = csn_q;
   assign bus.wrn_ram    = wrn_q;
   assign bus.addr_ram   = addr_q;
   assign bus.wr_dt_ram  = wdata_q;
   assign bus.delay      = delay_q;
   assign bus.en_mul     = en_q;
   assign bus.en_add_acc = en_q;
   assign bus.mac_valid  = valid_q;
   assign bus.busy       = !idle;
   assign bus.ovr        = ovr_q;
endmodule
